// File: rtl/mem_access.sv
// mem_access: MEM-stage data-bus access unit.
// Decodes load/store ops, drives a registered request/ack data bus with
// big-endian byte lanes, stalls the pipeline while a transfer is in flight,
// and extracts/extends load data for the MEM/WB register.

`ifndef EXE_LB_OP
`define EXE_LB_OP  8'b11100000
`endif
`ifndef EXE_LH_OP
`define EXE_LH_OP  8'b11100001
`endif
`ifndef EXE_LW_OP
`define EXE_LW_OP  8'b11100011
`endif
`ifndef EXE_LBU_OP
`define EXE_LBU_OP 8'b11100100
`endif
`ifndef EXE_LHU_OP
`define EXE_LHU_OP 8'b11100101
`endif
`ifndef EXE_SB_OP
`define EXE_SB_OP  8'b11101000
`endif
`ifndef EXE_SH_OP
`define EXE_SH_OP  8'b11101001
`endif
`ifndef EXE_SW_OP
`define EXE_SW_OP  8'b11101011
`endif

module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stallreq,
  output logic        align_err,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } state_t;

  state_t      state_reg;
  logic [31:0] rdata_q;

  // Decoded operation attributes
  logic        is_mem;
  logic        is_load;
  logic        is_store;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        ld_signed;
  logic        mem_go;

  // Lane select / replicated store data for the current op
  logic [3:0]  sel_next;
  logic [31:0] wdata_next;

  // Byte and halfword lanes of the captured read data, big-endian order:
  // lane 0 is the most significant byte (address offset 0).
  logic [7:0]  rd_byte [4];
  logic [15:0] rd_half [2];
  logic [3:0]  byte_onehot;

  // Opcode decode: classify the op by direction, size and signedness
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_word   = 1'b0;
    ld_signed = 1'b0;
    case (mem_aluop)
      `EXE_LB_OP:  begin is_load = 1'b1;  is_byte = 1'b1; ld_signed = 1'b1; end
      `EXE_LBU_OP: begin is_load = 1'b1;  is_byte = 1'b1; end
      `EXE_LH_OP:  begin is_load = 1'b1;  is_half = 1'b1; ld_signed = 1'b1; end
      `EXE_LHU_OP: begin is_load = 1'b1;  is_half = 1'b1; end
      `EXE_LW_OP:  begin is_load = 1'b1;  is_word = 1'b1; end
      `EXE_SB_OP:  begin is_store = 1'b1; is_byte = 1'b1; end
      `EXE_SH_OP:  begin is_store = 1'b1; is_half = 1'b1; end
      `EXE_SW_OP:  begin is_store = 1'b1; is_word = 1'b1; end
      default:     begin end
    endcase
  end

  assign is_mem = is_load | is_store;

  // Misalignment check is purely combinational so the pipeline sees it
  // in the same cycle the op arrives.
  assign align_err = (is_half & mem_mem_addr[0]) |
                     (is_word & (mem_mem_addr[1:0] != 2'b00));

  // An op that actually needs the bus
  assign mem_go = is_mem & ~align_err;

  // One-hot byte lane for a byte access: offset 0 maps to the MSB lane
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_onehot[3-gi] = (mem_mem_addr[1:0] == gi[1:0]);
      assign rd_byte[gi]       = rdata_q[31-8*gi -: 8];
    end
    for (gi = 0; gi < 2; gi++) begin : g_half
      assign rd_half[gi] = rdata_q[31-16*gi -: 16];
    end
  endgenerate

  // Lane select and replicated store data for the request about to issue
  always_comb begin
    sel_next   = 4'b0000;
    wdata_next = mem_reg2;
    if (is_byte) begin
      sel_next   = byte_onehot;
      wdata_next = {4{mem_reg2[7:0]}};
    end else if (is_half) begin
      sel_next   = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
      wdata_next = {2{mem_reg2[15:0]}};
    end else if (is_word) begin
      sel_next   = 4'b1111;
      wdata_next = mem_reg2;
    end
  end

  // Transfer FSM with registered bus outputs and read-data capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_sel   <= 4'b0000;
      bus_wdata <= 32'h0;
      rdata_q   <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mem_go && !flush) begin
            state_reg <= BUSY;
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_addr  <= mem_mem_addr;
            bus_sel   <= sel_next;
            bus_wdata <= wdata_next;
          end
        end
        BUSY: begin
          if (flush) begin
            // A flushed op may still be on the bus; an ack in the same
            // cycle finishes it, otherwise wait it out in ABORT.
            if (bus_ack) begin
              state_reg <= IDLE;
              bus_req   <= 1'b0;
              bus_we    <= 1'b0;
            end else begin
              state_reg <= ABORT;
            end
          end else if (bus_ack) begin
            state_reg <= DONE;
            rdata_q   <= bus_rdata;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
          end
        end
        DONE: begin
          // Result is visible for exactly this one cycle
          state_reg <= IDLE;
        end
        ABORT: begin
          // Bus protocol requires the outstanding request to complete;
          // its data is dropped.
          if (bus_ack) begin
            state_reg <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          bus_req   <= 1'b0;
          bus_we    <= 1'b0;
        end
      endcase
    end
  end

  // Hold the pipeline until the transfer result is presented in DONE
  assign stallreq = rst & mem_go & (state_reg != DONE);

  // Writeback pass-through; misaligned ops never write a register
  assign wb_wd   = mem_wd;
  assign wb_wreg = mem_wreg & ~align_err;

  // Load data extraction and extension, only while the result is presented
  always_comb begin
    wb_wdata = mem_wdata;
    if (state_reg == DONE && is_load) begin
      if (is_byte) begin
        wb_wdata = {{24{ld_signed & rd_byte[mem_mem_addr[1:0]][7]}},
                    rd_byte[mem_mem_addr[1:0]]};
      end else if (is_half) begin
        wb_wdata = {{16{ld_signed & rd_half[mem_mem_addr[1]][15]}},
                    rd_half[mem_mem_addr[1]]};
      end else begin
        wb_wdata = rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed scenario tests for mem_access.
// Inputs are driven 1 ns after the rising edge; outputs are checked on the
// falling edge.

module tb_mem_access;

  localparam logic [7:0] OP_LB  = 8'b11100000;
  localparam logic [7:0] OP_LH  = 8'b11100001;
  localparam logic [7:0] OP_LW  = 8'b11100011;
  localparam logic [7:0] OP_LBU = 8'b11100100;
  localparam logic [7:0] OP_LHU = 8'b11100101;
  localparam logic [7:0] OP_SB  = 8'b11101000;
  localparam logic [7:0] OP_SH  = 8'b11101001;
  localparam logic [7:0] OP_SW  = 8'b11101011;
  localparam logic [7:0] OP_OR  = 8'b00100101;
  localparam logic [7:0] OP_NOP = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stallreq;
  logic        align_err;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  mem_access dut (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_sel(bus_sel), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .stallreq(stallreq), .align_err(align_err),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] reg2, input logic [31:0] wdata);
    mem_aluop    = op;
    mem_mem_addr = addr;
    mem_reg2     = reg2;
    mem_wdata    = wdata;
    mem_wd       = 5'd5;
    mem_wreg     = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    set_op(OP_LW, 32'h0, 32'h0, 32'h0);
    #3;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", bus_req); end
    checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b exp 0", bus_we); end
    checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", bus_addr); end
    checks++; if (bus_sel !== 4'b0000) begin errors++; $display("FAIL reset_sel: got %b exp 0000", bus_sel); end
    checks++; if (bus_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h exp 0", bus_wdata); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", stallreq); end
    step(); step();
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_req_held: got %b exp 0", bus_req); end
    set_op(OP_NOP, 32'h0, 32'h0, 32'h0);
    rst = 1'b1;
    $display("txn reset: released");
  endtask

  task automatic test_lb();
    set_op(OP_LB, 32'h103, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL lb_stall_idle: got %b exp 1", stallreq); end
    step(); bus_ack = 1'b1; bus_rdata = 32'h112233F4;
    @(negedge clk);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL lb_req: got %b exp 1", bus_req); end
    checks++; if (bus_sel !== 4'b0001) begin errors++; $display("FAIL lb_sel: got %b exp 0001", bus_sel); end
    checks++; if (bus_addr !== 32'h103) begin errors++; $display("FAIL lb_addr: got %h exp 00000103", bus_addr); end
    checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL lb_we: got %b exp 0", bus_we); end
    checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL lb_stall_busy: got %b exp 1", stallreq); end
    step(); bus_ack = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL lb_stall_done: got %b exp 0", stallreq); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL lb_req_done: got %b exp 0", bus_req); end
    checks++; if (wb_wdata !== 32'hFFFFFFF4) begin errors++; $display("FAIL lb_wdata: got %h exp FFFFFFF4", wb_wdata); end
    checks++; if (wb_wreg !== 1'b1) begin errors++; $display("FAIL lb_wreg: got %b exp 1", wb_wreg); end
    checks++; if (wb_wd !== 5'd5) begin errors++; $display("FAIL lb_wd: got %0d exp 5", wb_wd); end
    $display("txn LB addr=00000103 wb_wdata=%h", wb_wdata);
    step(); set_op(OP_NOP, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_load_table();
    vec_t lv [6];
    lv[0] = '{OP_LBU, 32'h100, 32'h80112233, 4'b1000, 32'h00000080};
    lv[1] = '{OP_LB,  32'h101, 32'h11A23344, 4'b0100, 32'hFFFFFFA2};
    lv[2] = '{OP_LB,  32'h102, 32'h11223344, 4'b0010, 32'h00000033};
    lv[3] = '{OP_LH,  32'h200, 32'h8001FFFF, 4'b1100, 32'hFFFF8001};
    lv[4] = '{OP_LHU, 32'h202, 32'h12349ABC, 4'b0011, 32'h00009ABC};
    lv[5] = '{OP_LW,  32'h300, 32'h89ABCDEF, 4'b1111, 32'h89ABCDEF};
    for (int i = 0; i < 6; i++) begin
      set_op(lv[i].op, lv[i].addr, 32'h0, 32'h0);
      step(); bus_ack = 1'b1; bus_rdata = lv[i].data;
      @(negedge clk);
      checks++; if (bus_sel !== lv[i].sel) begin errors++; $display("FAIL load%0d_sel: got %b exp %b", i, bus_sel, lv[i].sel); end
      step(); bus_ack = 1'b0; bus_rdata = 32'h0;
      @(negedge clk);
      checks++; if (wb_wdata !== lv[i].exp) begin errors++; $display("FAIL load%0d_wdata: got %h exp %h", i, wb_wdata, lv[i].exp); end
      $display("txn load op=%h addr=%h wb_wdata=%h", lv[i].op, lv[i].addr, wb_wdata);
      step(); set_op(OP_NOP, 32'h0, 32'h0, 32'h0);
    end
  endtask

  task automatic test_sh_delayed();
    set_op(OP_SH, 32'h202, 32'h0000ABCD, 32'h11110000);
    @(negedge clk);
    checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL sh_stall_idle: got %b exp 1", stallreq); end
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus_ack = 1'b1;
      @(negedge clk);
      checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL sh_req_c%0d: got %b exp 1", i, bus_req); end
      checks++; if (bus_we !== 1'b1) begin errors++; $display("FAIL sh_we_c%0d: got %b exp 1", i, bus_we); end
      checks++; if (bus_sel !== 4'b0011) begin errors++; $display("FAIL sh_sel_c%0d: got %b exp 0011", i, bus_sel); end
      checks++; if (bus_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata_c%0d: got %h exp ABCDABCD", i, bus_wdata); end
      checks++; if (bus_addr !== 32'h202) begin errors++; $display("FAIL sh_addr_c%0d: got %h exp 00000202", i, bus_addr); end
      checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL sh_stall_c%0d: got %b exp 1", i, stallreq); end
      step();
    end
    bus_ack = 1'b0;
    @(negedge clk);
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL sh_req_done: got %b exp 0", bus_req); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL sh_stall_done: got %b exp 0", stallreq); end
    checks++; if (wb_wdata !== 32'h11110000) begin errors++; $display("FAIL sh_wb_wdata: got %h exp 11110000", wb_wdata); end
    $display("txn SH addr=00000202 bus_wdata=%h", bus_wdata);
    step(); set_op(OP_NOP, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_stores();
    vec_t sv [2];
    sv[0] = '{OP_SB, 32'h101, 32'hFFFFFFA5, 4'b0100, 32'hA5A5A5A5};
    sv[1] = '{OP_SW, 32'h104, 32'h12345678, 4'b1111, 32'h12345678};
    for (int i = 0; i < 2; i++) begin
      set_op(sv[i].op, sv[i].addr, sv[i].data, 32'h0);
      step(); bus_ack = 1'b1;
      @(negedge clk);
      checks++; if (bus_sel !== sv[i].sel) begin errors++; $display("FAIL store%0d_sel: got %b exp %b", i, bus_sel, sv[i].sel); end
      checks++; if (bus_wdata !== sv[i].exp) begin errors++; $display("FAIL store%0d_wdata: got %h exp %h", i, bus_wdata, sv[i].exp); end
      checks++; if (bus_we !== 1'b1) begin errors++; $display("FAIL store%0d_we: got %b exp 1", i, bus_we); end
      $display("txn store op=%h addr=%h bus_wdata=%h", sv[i].op, sv[i].addr, bus_wdata);
      step(); bus_ack = 1'b0;
      step(); set_op(OP_NOP, 32'h0, 32'h0, 32'h0);
    end
  endtask

  task automatic test_align();
    vec_t av [4];
    av[0] = '{OP_LW, 32'h006, 32'h0, 4'b0000, 32'h0};
    av[1] = '{OP_LH, 32'h001, 32'h0, 4'b0000, 32'h0};
    av[2] = '{OP_SH, 32'h203, 32'h0, 4'b0000, 32'h0};
    av[3] = '{OP_SW, 32'h102, 32'h0, 4'b0000, 32'h0};
    for (int i = 0; i < 4; i++) begin
      set_op(av[i].op, av[i].addr, 32'h0, 32'h0);
      @(negedge clk);
      checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL align%0d_err: got %b exp 1", i, align_err); end
      checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL align%0d_stall: got %b exp 0", i, stallreq); end
      checks++; if (wb_wreg !== 1'b0) begin errors++; $display("FAIL align%0d_wreg: got %b exp 0", i, wb_wreg); end
      step();
      @(negedge clk);
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL align%0d_req: got %b exp 0", i, bus_req); end
      $display("txn misaligned op=%h addr=%h align_err=%b", av[i].op, av[i].addr, align_err);
      step();
    end
    set_op(OP_NOP, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_nonmem();
    set_op(OP_OR, 32'h006, 32'h0, 32'h5A5A5A5A);
    mem_wd = 5'd3;
    @(negedge clk);
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL or_stall: got %b exp 0", stallreq); end
    checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL or_align: got %b exp 0", align_err); end
    checks++; if (wb_wdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL or_wdata: got %h exp 5A5A5A5A", wb_wdata); end
    checks++; if (wb_wreg !== 1'b1) begin errors++; $display("FAIL or_wreg: got %b exp 1", wb_wreg); end
    checks++; if (wb_wd !== 5'd3) begin errors++; $display("FAIL or_wd: got %0d exp 3", wb_wd); end
    step();
    @(negedge clk);
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL or_req: got %b exp 0", bus_req); end
    $display("txn OR wb_wdata=%h", wb_wdata);
    step(); set_op(OP_NOP, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_flush_idle();
    set_op(OP_LW, 32'h040, 32'h0, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0; set_op(OP_NOP, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL flush_idle_req: got %b exp 0", bus_req); end
    $display("txn flush in IDLE: bus_req=%b", bus_req);
    step();
  endtask

  task automatic test_abort();
    set_op(OP_LHU, 32'h000, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL abort_stall_idle: got %b exp 1", stallreq); end
    step(); flush = 1'b1;
    @(negedge clk);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL abort_req_busy: got %b exp 1", bus_req); end
    step(); flush = 1'b0; set_op(OP_LW, 32'h010, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL abort_req_held: got %b exp 1", bus_req); end
    checks++; if (bus_addr !== 32'h000) begin errors++; $display("FAIL abort_addr_held: got %h exp 0", bus_addr); end
    checks++; if (bus_sel !== 4'b1100) begin errors++; $display("FAIL abort_sel_held: got %b exp 1100", bus_sel); end
    checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL abort_stall: got %b exp 1", stallreq); end
    step(); bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL abort_req_ack: got %b exp 1", bus_req); end
    step(); bus_ack = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL abort_req_idle: got %b exp 0", bus_req); end
    checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL abort_lw_stall: got %b exp 1", stallreq); end
    step(); bus_ack = 1'b1; bus_rdata = 32'hCAFEBABE;
    @(negedge clk);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL abort_lw_req: got %b exp 1", bus_req); end
    checks++; if (bus_addr !== 32'h010) begin errors++; $display("FAIL abort_lw_addr: got %h exp 00000010", bus_addr); end
    checks++; if (bus_sel !== 4'b1111) begin errors++; $display("FAIL abort_lw_sel: got %b exp 1111", bus_sel); end
    step(); bus_ack = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    checks++; if (wb_wdata !== 32'hCAFEBABE) begin errors++; $display("FAIL abort_lw_wdata: got %h exp CAFEBABE", wb_wdata); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL abort_lw_stall_done: got %b exp 0", stallreq); end
    $display("txn LHU aborted, LW addr=00000010 wb_wdata=%h", wb_wdata);
    step(); set_op(OP_NOP, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_flush_ack();
    set_op(OP_LW, 32'h020, 32'h0, 32'h0);
    step(); flush = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h12345678;
    @(negedge clk);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL flushack_req_busy: got %b exp 1", bus_req); end
    step(); flush = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    set_op(OP_NOP, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL flushack_req: got %b exp 0", bus_req); end
    step();
    @(negedge clk);
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL flushack_req_idle: got %b exp 0", bus_req); end
    $display("txn flush with ack in BUSY: bus_req=%b", bus_req);
    step();
  endtask

  task automatic test_rst_mid();
    set_op(OP_SW, 32'h020, 32'h55AA55AA, 32'h0);
    step();
    @(negedge clk);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rstmid_req_busy: got %b exp 1", bus_req); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rstmid_req: got %b exp 0", bus_req); end
    checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL rstmid_we: got %b exp 0", bus_we); end
    checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL rstmid_addr: got %h exp 0", bus_addr); end
    checks++; if (bus_sel !== 4'b0000) begin errors++; $display("FAIL rstmid_sel: got %b exp 0000", bus_sel); end
    checks++; if (bus_wdata !== 32'h0) begin errors++; $display("FAIL rstmid_wdata: got %h exp 0", bus_wdata); end
    checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b exp 0", stallreq); end
    step();
    rst = 1'b1; bus_ack = 1'b1; set_op(OP_NOP, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rstmid_req_rel: got %b exp 0", bus_req); end
    step(); bus_ack = 1'b0;
    @(negedge clk);
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rstmid_late_ack: got %b exp 0", bus_req); end
    set_op(OP_LB, 32'h000, 32'h0, 32'h0);
    step(); bus_ack = 1'b1; bus_rdata = 32'h7F000000;
    @(negedge clk);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rstmid_new_req: got %b exp 1", bus_req); end
    checks++; if (bus_sel !== 4'b1000) begin errors++; $display("FAIL rstmid_new_sel: got %b exp 1000", bus_sel); end
    step(); bus_ack = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    checks++; if (wb_wdata !== 32'h0000007F) begin errors++; $display("FAIL rstmid_new_wdata: got %h exp 0000007F", wb_wdata); end
    $display("txn reset mid-transfer, then LB wb_wdata=%h", wb_wdata);
    step(); set_op(OP_NOP, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    test_reset();
    step();
    test_lb();
    test_load_table();
    test_sh_delayed();
    test_stores();
    test_align();
    test_nonmem();
    test_flush_idle();
    test_abort();
    test_flush_ack();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-004 flush  in  1  pipeline flush from the control unit.
REQ-005 mem_aluop  in  8  operation code from the EX/MEM register.
REQ-006 mem_mem_addr  in  32  effective byte address.
REQ-007 mem_reg2  in  32  store data.
REQ-008 mem_wd  in  5, mem_wreg  in  1, mem_wdata  in  32  writeback destination, enable and ALU result.
REQ-009 bus_req  out  1, bus_we  out  1, bus_addr  out  32, bus_sel  out  4, bus_wdata  out  32  data-bus request, all registered.
REQ-010 bus_ack  in  1, bus_rdata  in  32  data-bus completion and read data.
REQ-011 stallreq  out  1  requests a stall of the pipeline up to and including MEM.
REQ-012 align_err  out  1  misaligned load/store detected.
REQ-013 wb_wd  out  5, wb_wreg  out  1, wb_wdata  out  32  outputs to MEM/WB.

Function
REQ-014 SHALL decode these memory ops using the shared defines: EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP, EXE_SH_OP and EXE_SW_OP; every other op SHALL pass through with no bus activity.
REQ-015 SHALL use big-endian byte lanes.
  - Byte access: addr[1:0] 00/01/10/11 -> sel 1000/0100/0010/0001.
  - Halfword access: addr[1] 0/1 -> sel 1100/0011.
  - Word access: sel 1111.
REQ-016 Store data SHALL be replicated across lanes: SB {4{b}}, SH {2{h}}, SW the full word.
REQ-017 align_err SHALL be 1, combinationally, for a halfword op with addr[0]=1 or a word op with addr[1:0]!=00; a misaligned op SHALL issue no bus request and SHALL hold stallreq=0 and wb_wreg=0.
REQ-018 The FSM SHALL have states IDLE, BUSY, DONE and ABORT.
REQ-019 IDLE: an aligned memory op with flush=0 SHALL move the FSM to BUSY and, at that edge, register bus_req=1 together with addr, sel, we (1 for stores) and wdata.
REQ-020 BUSY: while bus_ack=0 the FSM SHALL hold and all bus outputs SHALL stay stable; bus_ack=1 SHALL capture bus_rdata into rdata_q, clear bus_req and move the FSM to DONE.
REQ-021 DONE: the FSM SHALL present the result for exactly one cycle, then return to IDLE.
REQ-022 stallreq SHALL be combinational and equal to 1 when an aligned memory op is present and the state is IDLE, BUSY or ABORT; it SHALL be 0 in DONE.
REQ-023 Minimum occupancy SHALL be 3 cycles (IDLE, BUSY with ack, DONE).
REQ-024 Load extraction in DONE:
  - LB/LH SHALL sign-extend the selected byte/halfword from rdata_q.
  - LBU/LHU SHALL zero-extend it.
  - LW SHALL pass rdata_q unchanged.
  - In all other cases wb_wdata SHALL equal mem_wdata.
REQ-025 wb_wd SHALL equal mem_wd, and wb_wreg SHALL equal mem_wreg AND NOT align_err.
REQ-026 Flush in IDLE or DONE SHALL force the FSM to IDLE and issue no request.
REQ-027 Flush in BUSY SHALL move the FSM to ABORT; ABORT SHALL keep bus_req=1 until bus_ack, then clear bus_req, discard the read data and return to IDLE.
REQ-028 A new memory op arriving in ABORT SHALL stall (REQ-022) and SHALL issue its request only after the FSM returns to IDLE.
REQ-029 Flush together with bus_ack in BUSY SHALL discard the data and go to IDLE.

Reset
REQ-030 rst=0 SHALL, asynchronously, set state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_sel=0000, bus_wdata=0 and rdata_q=0.
REQ-031 stallreq SHALL be 0 while rst=0.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction and SHALL NOT wait for bus_ack.

Verification
REQ-033 LB at addr 0x103, bus_rdata=0x112233F4 with ack in the first BUSY cycle -> sel=0001, stallreq high for 2 cycles, wb_wdata=0xFFFFFFF4 in DONE.
REQ-034 SH at addr 0x202, reg2=0x0000ABCD -> bus_we=1, sel=0011, bus_wdata=0xABCDABCD; an ack delayed 3 cycles holds all bus outputs stable.
REQ-035 LW at addr 0x006 -> align_err=1, bus_req stays 0, stallreq=0, wb_wreg=0.
REQ-036 LHU at addr 0x000 with flush during BUSY -> ABORT, bus_req held until ack, data discarded, return to IDLE; a following LW stalls until IDLE, then issues.
REQ-037 rst pulsed low during BUSY -> all registered outputs are 0 immediately; after release the state is IDLE and a late bus_ack is ignored.
REQ-038 Non-memory op (e.g. OR) with mem_wdata=0x5A5A5A5A -> no request, stallreq=0, wb_wdata=0x5A5A5A5A.
